// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_H,
        LEN_L,
        DATA,
        CHK,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         LEN_W     = 16;

endpackage

// File: rtl/prog_loader_byte_to_word.sv
// Four-lane little-endian byte-to-word assembler; word_vld is combinational with the lane-3 byte.
// No backpressure: accepts one byte per cycle whenever in_vld is high.
module prog_loader_byte_to_word (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_vld,
    input  logic [7:0]  in_dat,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] sh_q, sh_d;

    always_comb begin
        lane_d = lane_q;
        sh_d   = sh_q;
        if (clear) begin
            lane_d = 2'd0;
            sh_d   = 24'd0;
        end else if (in_vld) begin
            lane_d = lane_q + 2'd1;
            sh_d   = {in_dat, sh_q[23:8]};
        end
    end

    // After three bytes sh_q holds {b2, b1, b0}, so the fourth byte completes the word.
    assign word_vld = in_vld && !clear && (lane_q == 2'd3);
    assign word_dat = {in_dat, sh_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= 2'd0;
            sh_q   <= 24'd0;
        end else begin
            lane_q <= lane_d;
            sh_q   <= sh_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader into instruction memory; holds the core in reset until the checksum matches.
// One byte per cycle; rx_ready is registered and drops only once the load has completed.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             mem_wr,
    output logic [31:0]      mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic             core_reset,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_loaded
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    loader_state_t    state_q, state_d;
    logic [7:0]       len_h_q, len_h_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic             rx_ready_q, rx_ready_d;
    logic             mem_wr_q, mem_wr_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             core_reset_q, core_reset_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             accept;
    logic             lane_clr;
    logic             b2w_vld;
    logic             word_vld;
    logic [31:0]      word_dat;
    logic [LEN_W-1:0] n_rx;

    assign accept = rx_valid && rx_ready_q;
    assign n_rx   = {len_h_q, rx_data};

    prog_loader_byte_to_word u_byte_to_word (
        .clk      (clk),
        .rst_n    (reset),
        .clear    (lane_clr),
        .in_vld   (b2w_vld),
        .in_dat   (rx_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_comb begin
        state_d      = state_q;
        len_h_d      = len_h_q;
        len_d        = len_q;
        idx_d        = idx_q;
        chk_d        = chk_q;
        mem_wr_d     = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        error_d      = error_q;
        lane_clr     = 1'b0;
        b2w_vld      = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE, ERR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d  = LEN_H;
                        error_d  = 1'b0;
                        chk_d    = 8'd0;
                        idx_d    = '0;
                        lane_clr = 1'b1;
                    end
                end
                LEN_H: begin
                    len_h_d = rx_data;
                    state_d = LEN_L;
                end
                LEN_L: begin
                    len_d = n_rx;
                    if (n_rx > MAX_LEN) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else if (n_rx == '0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    b2w_vld = 1'b1;
                    chk_d   = chk_q ^ rx_data;
                    if (word_vld) begin
                        mem_wr_d = 1'b1;
                        wdata_d  = word_dat;
                        waddr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        idx_d    = idx_q + 1'b1;
                        if (idx_q + 1'b1 == len_q) begin
                            state_d = CHK;
                        end
                    end
                end
                CHK: begin
                    if (rx_data == chk_q) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        core_reset_d = 1'b0;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
        rx_ready_d = (state_d != DONE);
    end

    // core_reset presets asynchronously so the core is held the instant reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            len_h_q      <= 8'd0;
            len_q        <= '0;
            idx_q        <= '0;
            chk_q        <= 8'd0;
            rx_ready_q   <= 1'b0;
            mem_wr_q     <= 1'b0;
            waddr_q      <= BASE_ADDR;
            wdata_q      <= 32'd0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_h_q      <= len_h_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            chk_q        <= chk_d;
            rx_ready_q   <= rx_ready_d;
            mem_wr_q     <= mem_wr_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign mem_wr       = mem_wr_q;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = wdata_q;
    assign core_reset   = core_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = idx_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frames are built from word lists, expected writes queued, a monitor checks mem_wr.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_wr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks   = 0;
    int failures = 0;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] fw[$];

    prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_wr       (mem_wr),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_waddr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", mem_waddr, mon_e.a);
                check("wr_data", mem_wdata, mon_e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout: got rx_ready %b expected 1", rx_ready);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Reference: writes at BASE+4i for each listed word, checksum = XOR of payload bytes.
    task automatic send_frame(input logic [15:0] n, input logic [7:0] chk_delta, input int max_gap);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] w;
        x = 8'd0;
        if (int'(n) <= MAXW)
            for (int i = 0; i < int'(n); i++)
                exp_q.push_back('{a: BASE + 32'(4 * i), d: fw[i]});
        send_byte(8'hA5, $urandom_range(0, max_gap));
        send_byte(n[15:8], $urandom_range(0, max_gap));
        send_byte(n[7:0], $urandom_range(0, max_gap));
        if (int'(n) > MAXW) return;
        for (int i = 0; i < int'(n); i++) begin
            w = fw[i];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                x = x ^ b;
                send_byte(b, $urandom_range(0, max_gap));
            end
        end
        send_byte(x ^ chk_delta, $urandom_range(0, max_gap));
    endtask

    task automatic check_end(input string tag, input logic e_done, input logic e_err, input logic [15:0] e_wl);
        check({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
        check({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
        check({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, !e_done});
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, {31'd0, !e_done});
        check({tag, "_words_loaded"}, {16'd0, words_loaded}, {16'd0, e_wl});
        check({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        check({tag, "_mem_waddr"}, mem_waddr, BASE);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'd0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        rx_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic rand_words(input int n);
        logic [31:0] w;
        fw.delete();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[15:8] = 8'hA5;
            fw.push_back(w);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [7:0]  d;
        logic [7:0]  junk;
        logic [31:0] w0;
        logic [31:0] w1;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset("por");
        reset = 1'b1;
        @(posedge clk);
        #1 check("rdy_after_reset", {31'd0, rx_ready}, 32'd1);

        // Single-word frame A5 00 01 13 00 00 00 13
        fw = {32'h0000_0013};
        send_frame(16'd1, 8'd0, 0);
        check_end("one_word", 1'b1, 1'b0, 16'd1);

        do_reset();
        fw = {32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        send_frame(16'd3, 8'd0, 3);
        check_end("three_words", 1'b1, 1'b0, 16'd3);

        do_reset();
        send_frame(16'd3, 8'd1, 2);
        check_end("bad_chk", 1'b0, 1'b1, 16'd3);
        rand_words(5);
        send_frame(16'd5, 8'd0, 2);
        check_end("after_bad", 1'b1, 1'b0, 16'd5);

        // Junk before sync, oversize length, then an empty frame
        do_reset();
        for (int i = 0; i < 4; i++) begin
            junk = 8'($urandom);
            if (junk == 8'hA5) junk = 8'h00;
            send_byte(junk, $urandom_range(0, 2));
        end
        fw.delete();
        send_frame(16'h0401, 8'd0, 1);
        check_end("too_long", 1'b0, 1'b1, 16'd0);
        send_frame(16'd0, 8'd0, 1);
        check_end("empty", 1'b1, 1'b0, 16'd0);

        // Abort after the 2nd payload byte of word 1
        do_reset();
        w0 = $urandom | 32'h1;
        w1 = $urandom;
        exp_q.push_back('{a: BASE, d: w0});
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int k = 0; k < 4; k++) begin
            d = w0[8*k +: 8];
            send_byte(d, 0);
        end
        d = w1[7:0];
        send_byte(d, 1);
        d = w1[15:8];
        send_byte(d, 0);
        #1 reset = 1'b0;
        #1 check_reset("abort");
        check("abort_pending_writes", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rand_words(4);
        send_frame(16'd4, 8'd0, 1);
        check_end("post_abort", 1'b1, 1'b0, 16'd4);

        for (int r = 0; r < 6; r++) begin
            do_reset();
            n = $urandom_range(1, 6);
            rand_words(n);
            d = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            send_frame(16'(n), d, 2);
            check_end("random", d == 8'd0, d != 8'd0, 16'(n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
